// File: rtl/square_bank_controller_if.sv
// Bus between the button/debounce front end and the square bank controller:
// direction levels, frame tick, selection/load controls and the registered position bank.
interface square_bank_controller_if #(
   parameter int NUM_SQUARES = 4
);
   logic                      btnU, btnL, btnD, btnR;
   logic                      refresh_tick;
   logic                      status;
   logic                      sel_next;
   logic                      load_en;
   logic [3:0]                load_idx;
   logic [19:0]               load_pos;
   logic [20*NUM_SQUARES-1:0] positions;
   logic [3:0]                sel;
   logic [3:0]                step;

   modport master (
      output btnU, btnL, btnD, btnR, refresh_tick, status, sel_next,
             load_en, load_idx, load_pos,
      input  positions, sel, step
   );

   modport slave (
      input  btnU, btnL, btnD, btnR, refresh_tick, status, sel_next,
             load_en, load_idx, load_pos,
      output positions, sel, step
   );
endinterface

// File: rtl/square_bank_controller.sv
// Holds a bank of {y,x} square positions and moves the selected one on frame ticks,
// with hold-to-accelerate stepping and clamp or wrap-around borders.
module square_bank_controller #(
   parameter int NUM_SQUARES = 4,
   parameter int X_MAX       = 640,
   parameter int Y_MAX       = 480,
   parameter int SQUARE_SIZE = 30,
   parameter int STEP_MIN    = 1,
   parameter int STEP_MAX    = 8,
   parameter int ACCEL_TICKS = 4,
   parameter int WRAP        = 0,
   parameter int INIT_Y      = 220
) (
   input logic                     clk,
   input logic                     reset,
   square_bank_controller_if.slave bus
);
   localparam int X_LIM = X_MAX - SQUARE_SIZE;
   localparam int Y_LIM = Y_MAX - SQUARE_SIZE;
   // First held count whose step reaches STEP_MAX; the counter parks there.
   localparam int H_SAT = (STEP_MAX - STEP_MIN) * ACCEL_TICKS + 1;
   localparam int H_W   = $clog2(H_SAT + 2);

   function automatic logic [3:0] step_of(input logic [H_W-1:0] h);
      int s;
      s = STEP_MIN + (int'(h) - 1) / ACCEL_TICKS;
      if (s > STEP_MAX) s = STEP_MAX;
      return 4'(s);
   endfunction

   function automatic logic signed [10:0] axis_delta(input logic plus, input logic minus,
                                                     input logic [3:0] s);
      logic signed [10:0] m;
      m = signed'({7'd0, s});
      if (plus && !minus) return m;
      else if (minus && !plus) return -m;
      else return '0;
   endfunction

   function automatic logic signed [10:0] fit_border(input logic signed [10:0] v,
                                                     input logic signed [10:0] lim);
      if (v < 0) return (WRAP != 0) ? lim : '0;
      else if (v > lim) return (WRAP != 0) ? '0 : lim;
      else return v;
   endfunction

   logic [19:0]        pos_p1 [NUM_SQUARES];
   logic [3:0]         sel_p1;
   logic [3:0]         step_p1;
   logic [H_W-1:0]     h_p1;
   logic               sel_next_p1;

   logic               any_btn_p0, mv_vld_p0, idle_p0, sel_rise_p0;
   logic [H_W-1:0]     h_inc_p0;
   logic [3:0]         step_new_p0, sel_adv_p0;
   logic [19:0]        cur_pos_p0, moved_pos_p0;
   logic signed [10:0] cur_x_p0, cur_y_p0, new_x_p0, new_y_p0;

   // Stage p0: decode the tick, pick the selected square and compute its next position.
   assign any_btn_p0  = bus.btnU | bus.btnL | bus.btnD | bus.btnR;
   assign mv_vld_p0   = bus.refresh_tick & bus.status & any_btn_p0;
   assign idle_p0     = bus.refresh_tick & bus.status & ~any_btn_p0;
   assign sel_rise_p0 = bus.sel_next & ~sel_next_p1;
   assign h_inc_p0    = (h_p1 >= H_W'(H_SAT)) ? h_p1 : h_p1 + H_W'(1);
   assign step_new_p0 = step_of(h_inc_p0);
   assign sel_adv_p0  = (sel_p1 == 4'(NUM_SQUARES - 1)) ? 4'd0 : sel_p1 + 4'd1;

   always_comb begin
      cur_pos_p0 = '0;
      for (int i = 0; i < NUM_SQUARES; i++)
         if (sel_p1 == 4'(i)) cur_pos_p0 = pos_p1[i];
   end

   assign cur_x_p0     = signed'({1'b0, cur_pos_p0[9:0]});
   assign cur_y_p0     = signed'({1'b0, cur_pos_p0[19:10]});
   assign new_x_p0     = fit_border(cur_x_p0 + axis_delta(bus.btnR, bus.btnL, step_new_p0),
                                    11'(X_LIM));
   assign new_y_p0     = fit_border(cur_y_p0 + axis_delta(bus.btnD, bus.btnU, step_new_p0),
                                    11'(Y_LIM));
   assign moved_pos_p0 = {new_y_p0[9:0], new_x_p0[9:0]};

   // Stage p1: registered bank, selection, step and held counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_SQUARES; i++)
            pos_p1[i] <= {10'(INIT_Y), 10'(2 * i * SQUARE_SIZE)};
         sel_p1      <= '0;
         step_p1     <= '0;
         h_p1        <= '0;
         sel_next_p1 <= 1'b0;
      end else begin
         sel_next_p1 <= bus.sel_next;
         if (mv_vld_p0) step_p1 <= step_new_p0;
         else if (idle_p0) step_p1 <= '0;
         // A selection change restarts acceleration even when a move lands in the same cycle.
         if (sel_rise_p0) h_p1 <= '0;
         else if (mv_vld_p0) h_p1 <= h_inc_p0;
         else if (idle_p0) h_p1 <= '0;
         if (sel_rise_p0) sel_p1 <= sel_adv_p0;
         for (int i = 0; i < NUM_SQUARES; i++) begin
            if (bus.load_en && bus.load_idx == 4'(i)) pos_p1[i] <= bus.load_pos;
            else if (mv_vld_p0 && sel_p1 == 4'(i)) pos_p1[i] <= moved_pos_p0;
         end
      end
   end

   for (genvar g = 0; g < NUM_SQUARES; g++) begin : g_pos
      assign bus.positions[20*g +: 20] = pos_p1[g];
   end
   assign bus.sel  = sel_p1;
   assign bus.step = step_p1;
endmodule

// File: doc/square_bank_controller.md
# square_bank_controller

Position controller for a bank of on-screen squares. It holds NUM_SQUARES packed {y,x} positions, moves the currently selected square from the four direction buttons on each frame refresh tick, and applies hold-to-accelerate step sizing with either clamp or wrap-around borders. It sits between the button/debounce logic and the pixel renderer, and replaces per-square single-instance controllers.

## Interface
- NUM_SQUARES, 4: squares held, 1..16
- X_MAX, 640: right border of the display area, in pixels
- Y_MAX, 480: bottom border of the display area
- SQUARE_SIZE, 30: square side, in pixels
- STEP_MIN, 1: step on the first held tick
- STEP_MAX, 8: step ceiling
- ACCEL_TICKS, 4: held ticks per +1 step increment
- WRAP, 0: 0 = clamp at borders, 1 = wrap to the opposite edge
- INIT_Y, 220: reset y of every square
- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-low reset
- btnU, btnL, btnD, btnR  in  1 each  direction levels, already debounced
- refresh_tick  in  1  one-cycle pulse per frame
- status  in  1  movement enable; 0 freezes movement, but selection and load still work
- sel_next  in  1  level; its rising edge advances the selection
- load_en  in  1  direct position write
- load_idx  in  4  square index for load
- load_pos  in  20  {y[19:10], x[9:0]} for load
- positions  out  20*NUM_SQUARES  square i at [20i+19:20i], {y,x}
- sel  out  4  selected index
- step  out  4  step used on the last move tick

## Operation
- Reset: square i goes to x = 2·i·SQUARE_SIZE, y = INIT_Y. Also sel=0, step=0, held counter=0, and the sel_next edge register=0.
- Selection: a rising edge of sel_next sets sel ← sel+1, wrapping NUM_SQUARES-1 → 0. The same edge clears the held counter.
- Move tick: refresh_tick=1, status=1, and at least one direction button asserted.
  - Held counter h increments and saturates once the step reaches STEP_MAX.
  - Step = min(STEP_MAX, STEP_MIN + (h-1)/ACCEL_TICKS), with h counting from 1 on the first held tick.
- A refresh_tick with status=1 and no button asserted clears h and sets step=0.
- A refresh_tick with status=0 changes nothing, including h.
- Opposing buttons asserted together (L+R, or U+D) give no motion on that axis. The other axis still moves, and h still advances.
- Arithmetic is done in 11-bit signed form. Legal x range is 0..X_MAX-SQUARE_SIZE; legal y range is 0..Y_MAX-SQUARE_SIZE.
- WRAP=0: a result beyond a border is clamped to that border.
- WRAP=1: a result beyond a border is set to the opposite border. Underflow gives X_MAX-SQUARE_SIZE; overflow gives 0.
- Load: when load_en=1 and load_idx<NUM_SQUARES, positions[load_idx] ← load_pos, written verbatim with no clamp.
  - load_idx ≥ NUM_SQUARES is ignored.
  - Load has priority over movement when both target the same square in the same cycle.
- Only the selected square moves. Unselected squares hold their positions.

## Timing
- All outputs are registered. A move tick or load in cycle t is visible on positions in cycle t+1.
- A sel_next rising edge sampled in cycle t gives the new sel in cycle t+1.
- sel_next edge and move tick in the same cycle: the move applies to the old sel. sel then advances, and h is cleared instead of incremented.
- Asynchronous reset mid-move: all state returns to reset values immediately. The first tick after release uses step STEP_MIN.
- sel_next held high gives exactly one advance.

## Test plan
- Reset, then release: positions = {220,0},{220,60},{220,120},{220,180}; sel=0; step=0.
- btnR held for 10 ticks on square 0: steps 1,1,1,1,2,2,2,2,3,3; x=18; step=3.
- WRAP=0, sel=3, x loaded to 605, btnR held at step 2: x=607, then 609, 610, 610 (clamp at 610).
- WRAP=1, x=0, btnL tick: x=610. y=450, btnD tick: y=0.
- btnL+btnR+btnU on square 0 (y=220) for 1 tick: x unchanged, y=219. Then a tick with no buttons: step=0. The next btnU tick uses step 1.
- sel_next pulse coincident with a btnD tick: square 0 y=221, sel=1. The next btnD tick moves square 1 by step 1. A coincident load_en to square 1 with {100,100} wins over the move.
